// File: rtl/fsm_common_pkg.sv
// Shared state encoding and counter-width helper for the serial bit source.
// The SERIAL_PARITY_BIT_EN build makes use of ST_PARITY.
package fsm_common_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Counter width for 0..width-1, never narrower than one bit
    function automatic int clog2w(input int width);
        int w;
        w = 1;
        while ((1 << w) < width) w++;
        return w;
    endfunction

endpackage

// File: rtl/serial_bit_source_if.sv
// Parallel-in handshake plus serial-out/frame-marker bundle for serial_bit_source.
interface serial_bit_source_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             ser_last;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_out, ser_valid, frame_start, ser_last, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_out, ser_valid, frame_start, ser_last, busy
    );
endinterface

// File: rtl/ser_bit_counter.sv
// Bit-position counter: load clears it to zero, enable steps it up to WIDTH-1 and holds.
// tc flags the final data bit of a frame.
module ser_bit_counter
    import fsm_common_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = clog2w(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);

    assign tc = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= '0;
        else if (en && !tc)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial feeder with frame markers; one bit per clock on ser_out.
// Define SERIAL_PARITY_BIT_EN to append an even-parity bit to every frame.
//
// state     | meaning
// ST_IDLE   | no frame, in_ready high, ser_valid low
// ST_SHIFT  | presenting data bit <count> of the current word
// ST_PARITY | presenting the parity bit (parity build only)
module serial_bit_source
    import fsm_common_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    serial_bit_source_if.slave  bus
);

    localparam int CW = clog2w(WIDTH);

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]   count;
    logic            tc;
    logic            accept;
    logic            data_bit;

    assign accept   = bus.in_valid && bus.in_ready;
    assign data_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    ser_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .en    (state == ST_SHIFT),
        .count (count),
        .tc    (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:
                if (accept) state_nxt = ST_SHIFT;
            ST_SHIFT:
                if (tc) begin
`ifdef SERIAL_PARITY_BIT_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = accept ? ST_SHIFT : ST_IDLE;
`endif
                end
`ifdef SERIAL_PARITY_BIT_EN
            ST_PARITY:
                state_nxt = accept ? ST_SHIFT : ST_IDLE;
`endif
            default:
                state_nxt = ST_IDLE;
        endcase
    end

`ifdef SERIAL_PARITY_BIT_EN
    logic parity;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            parity <= 1'b0;
        else if (accept)
            parity <= ^bus.in_data;
    end
`endif

    // in_ready depends only on state/terminal count, so accept has no comb loop
    always_comb begin
        bus.in_ready    = 1'b0;
        bus.ser_valid   = 1'b0;
        bus.ser_out     = 1'b0;
        bus.frame_start = 1'b0;
        bus.ser_last    = 1'b0;
        bus.busy        = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
            end
            ST_SHIFT: begin
                bus.ser_valid   = 1'b1;
                bus.busy        = 1'b1;
                bus.ser_out     = data_bit;
                bus.frame_start = (count == '0);
`ifndef SERIAL_PARITY_BIT_EN
                bus.ser_last    = tc;
                bus.in_ready    = tc;
`endif
            end
`ifdef SERIAL_PARITY_BIT_EN
            ST_PARITY: begin
                bus.ser_valid = 1'b1;
                bus.busy      = 1'b1;
                bus.ser_out   = parity;
                bus.ser_last  = 1'b1;
                bus.in_ready  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            shreg <= '0;
        else if (accept)
            shreg <= bus.in_data;
        else if (state == ST_SHIFT)
            shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    end

endmodule

// File: tb/tb_serial_bit_source.sv
// Directed bench for serial_bit_source: MSB-first and LSB-first instances share stimulus.
// Parity frames are exercised when SERIAL_PARITY_BIT_EN is defined.
module tb_serial_bit_source;

`ifdef SERIAL_PARITY_BIT_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       vin;
    int         n_vec;
    int         n_err;

    serial_bit_source_if #(.WIDTH(8)) if_m ();
    serial_bit_source_if #(.WIDTH(8)) if_l ();

    assign if_m.in_data  = din;
    assign if_m.in_valid = vin;
    assign if_l.in_data  = din;
    assign if_l.in_valid = vin;

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (if_m)
    );

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (if_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_bit(input logic [7:0] d, input int i, input bit lsb);
        if (i >= 8) return ^d;
        return lsb ? d[i] : d[7 - i];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // packed as {ser_out, ser_valid, frame_start, ser_last, busy, in_ready}
    task automatic check_idle(input string tag);
        chk({tag, "_m"}, {2'b00, if_m.ser_out, if_m.ser_valid, if_m.frame_start,
                          if_m.ser_last, if_m.busy, if_m.in_ready}, 8'b0000_0001);
        chk({tag, "_l"}, {2'b00, if_l.ser_out, if_l.ser_valid, if_l.frame_start,
                          if_l.ser_last, if_l.busy, if_l.in_ready}, 8'b0000_0001);
    endtask

    task automatic check_bit(input logic [7:0] d, input int i);
        logic fin;
        logic fs;
        fin = (i == FL - 1);
        fs  = (i == 0);
        chk($sformatf("bit_m_%02h_%0d", d, i),
            {2'b00, if_m.ser_out, if_m.ser_valid, if_m.frame_start,
             if_m.ser_last, if_m.busy, if_m.in_ready},
            {2'b00, exp_bit(d, i, 1'b0), 1'b1, fs, fin, 1'b1, fin});
        chk($sformatf("bit_l_%02h_%0d", d, i),
            {2'b00, if_l.ser_out, if_l.ser_valid, if_l.frame_start,
             if_l.ser_last, if_l.busy, if_l.in_ready},
            {2'b00, exp_bit(d, i, 1'b1), 1'b1, fs, fin, 1'b1, fin});
    endtask

    task automatic send(input logic [7:0] d);
        din = d;
        vin = 1'b1;
        @(posedge clk); #1;
        vin = 1'b0;
        for (int i = 0; i < FL; i++) begin
            check_bit(d, i);
            @(posedge clk); #1;
        end
        check_idle($sformatf("idle_after_%02h", d));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // reset held with a valid word pending: nothing may start
        reset = 1'b1;
        vin   = 1'b1;
        din   = 8'hB2;
        repeat (2) @(posedge clk);
        #1;
        check_idle("in_reset");
        vin   = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle("post_reset");

        send(8'hB2);
        send(8'h01);

        // back-to-back frames, in_data changed mid-frame must be ignored
        din = 8'hFF;
        vin = 1'b1;
        @(posedge clk); #1;
        din = 8'h00;
        for (int i = 0; i < FL; i++) begin
            check_bit(8'hFF, i);
            @(posedge clk); #1;
        end
        vin = 1'b0;
        for (int i = 0; i < FL; i++) begin
            check_bit(8'h00, i);
            @(posedge clk); #1;
        end
        check_idle("idle_after_b2b");

        // reset mid-frame at bit 4
        din = 8'hA5;
        vin = 1'b1;
        @(posedge clk); #1;
        vin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_bit(8'hA5, i);
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        reset = 1'b1;
        #1;
        check_idle("mid_frame_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle("after_mid_reset");
        send(8'h3C);

`ifdef SERIAL_PARITY_BIT_EN
        send(8'h07);
        send(8'h03);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
